// File: rtl/fifo_rd_pkg.sv
// Shared state encoding and default widths for the async-FIFO read drainer.
// No logic; constants and types only.
// Imported by fifo_rd_drain and fifo_rd_skid2.
package fifo_rd_pkg;

  localparam int DSIZE_DEF = 32;
  localparam int CSIZE_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/fifo_rd_skid2.sv
// Two-entry in-order skid buffer between the async FIFO pop and the downstream port.
// Latency: a word pushed at edge N is the head after edge N when the buffer was empty.
// Backpressure: a push is refused when full unless a pop happens in the same cycle; head held while not popped.
module fifo_rd_skid2 #(
  parameter int DSIZE = fifo_rd_pkg::DSIZE_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [DSIZE-1:0] push_data,
  input  logic             pop,
  output logic [1:0]       occupancy,
  output logic [DSIZE-1:0] head
);

  logic [DSIZE-1:0] entry0;
  logic [DSIZE-1:0] entry1;
  logic [1:0]       occ;
  logic             do_pop;
  logic             do_push;

  assign do_pop    = pop && (occ != 2'd0);
  assign do_push   = push && ((occ != 2'd2) || do_pop);
  assign occupancy = occ;
  assign head      = entry0;

  // Entry storage and occupancy; entry0 is always the oldest word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      entry0 <= '0;
      entry1 <= '0;
      occ    <= 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (occ == 2'd0) entry0 <= push_data;
          else             entry1 <= push_data;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          entry0 <= entry1;
          occ    <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            entry0 <= push_data;
          end else begin
            entry0 <= entry1;
            entry1 <= push_data;
          end
        end
        default: begin
          occ <= occ;
        end
      endcase
    end
  end

endmodule

// File: rtl/fifo_rd_drain.sv
// Drains a requested burst of words from an async FIFO read port to a valid/ready stream, with count and checksum.
// Latency: word popped at edge N appears on m_data/m_valid after edge N when the skid buffer is empty.
// Backpressure: rinc stops when the 2-entry skid is full; m_ready never feeds rinc combinationally.
module fifo_rd_drain
  import fifo_rd_pkg::*;
#(
  parameter int DSIZE = DSIZE_DEF,
  parameter int CSIZE = CSIZE_DEF
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             start,
  input  logic [CSIZE-1:0] len,
  input  logic             rempty,
  input  logic [DSIZE-1:0] rdata,
  output logic             rinc,
  output logic [DSIZE-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             busy,
  output logic             done,
  output logic [CSIZE-1:0] rd_count,
  output logic [DSIZE-1:0] checksum
);

  state_t           state;
  state_t           state_nxt;
  logic [CSIZE-1:0] remaining;
  logic [1:0]       occupancy;
  logic             start_acc;
  logic             pop;

  assign start_acc = (state == IDLE) && start;
  assign rinc      = (state == READ) && !rempty && (remaining != '0) && (occupancy != 2'd2);
  assign m_valid   = (occupancy != 2'd0);
  assign pop       = m_valid && m_ready;
  assign busy      = (state == READ) || (state == FLUSH);
  assign done      = (state == DONE);

  // State register.
  always_ff @(posedge rclk) begin
    if (!rrst_n) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic; READ lingers one cycle after the last pop before flushing.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) state_nxt = (len == '0) ? DONE : READ;
      end
      READ: begin
        if (remaining == '0) state_nxt = FLUSH;
      end
      FLUSH: begin
        if (occupancy == 2'd0) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Burst bookkeeping: cleared on an accepted start, stepped on every pop, held otherwise.
  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      remaining <= '0;
      rd_count  <= '0;
      checksum  <= '0;
    end else if (start_acc) begin
      remaining <= len;
      rd_count  <= '0;
      checksum  <= '0;
    end else if (rinc) begin
      remaining <= remaining - CSIZE'(1);
      rd_count  <= rd_count + CSIZE'(1);
      checksum  <= checksum + rdata;
    end
  end

  fifo_rd_skid2 #(
    .DSIZE(DSIZE)
  ) u_skid (
    .clk       (rclk),
    .rst_n     (rrst_n),
    .push      (rinc),
    .push_data (rdata),
    .pop       (pop),
    .occupancy (occupancy),
    .head      (m_data)
  );

endmodule

// File: tb/tb_fifo_rd_drain.sv
// Self-checking bench for fifo_rd_drain with a queue-based async FIFO model and stream scoreboard.
// Inputs change just after the falling edge; outputs are sampled a little later in the low phase.
// Expected data, counts and checksums come from the words the bench itself writes.
module tb_fifo_rd_drain;

  logic        rclk;
  logic        rrst_n;
  logic        start;
  logic [7:0]  len;
  logic        rempty;
  logic [31:0] rdata;
  logic        rinc;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        busy;
  logic        done;
  logic [7:0]  rd_count;
  logic [31:0] checksum;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] q[$];
  logic [31:0] exp_q[$];
  logic [31:0] dummy;
  logic        pop_flag = 1'b0;
  int          rinc_cnt = 0;
  int          done_cnt = 0;
  int          stall_cnt = 0;
  logic        busy_seen = 1'b0;
  logic        prev_ok = 1'b0;
  logic        prev_v = 1'b0;
  logic        prev_r = 1'b0;
  logic [31:0] prev_d = '0;

  fifo_rd_drain dut (
    .rclk     (rclk),
    .rrst_n   (rrst_n),
    .start    (start),
    .len      (len),
    .rempty   (rempty),
    .rdata    (rdata),
    .rinc     (rinc),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .busy     (busy),
    .done     (done),
    .rd_count (rd_count),
    .checksum (checksum)
  );

  initial rclk = 1'b0;
  always #16 rclk = ~rclk;

  // Async FIFO read-port model plus stream monitor.
  always begin
    @(negedge rclk);
    if (pop_flag && q.size() > 0) dummy = q.pop_front();
    rempty = (q.size() == 0);
    rdata  = rempty ? 32'd0 : q[0];
    #2;
    pop_flag = rinc;
    if (rinc === 1'b1) begin
      rinc_cnt++;
      n_cmp++;
      if (rempty !== 1'b0) begin
        n_err++;
        $display("FAIL rinc_while_empty: rempty=%0b required 0", rempty);
      end
    end
    if (m_valid === 1'b1 && m_ready === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL stream_extra: got word %0d, required none", m_data);
      end else begin
        dummy = exp_q.pop_front();
        if (m_data !== dummy) begin
          n_err++;
          $display("FAIL stream_data: got %0d required %0d", m_data, dummy);
        end
      end
    end
    if (prev_ok && prev_v && !prev_r) begin
      n_cmp++;
      if (m_valid !== 1'b1 || m_data !== prev_d) begin
        n_err++;
        $display("FAIL stream_hold: got v=%0b d=%0d required v=1 d=%0d", m_valid, m_data, prev_d);
      end
    end
    if (done === 1'b1) done_cnt++;
    if (busy === 1'b1) busy_seen = 1'b1;
    if (busy === 1'b1 && rempty) stall_cnt++;
    prev_ok = rrst_n;
    prev_v  = m_valid;
    prev_r  = m_ready;
    prev_d  = m_data;
  end

  task automatic preload(input logic [31:0] w);
    q.push_back(w);
    exp_q.push_back(w);
  endtask

  task automatic do_start(input logic [7:0] l);
    @(negedge rclk);
    start = 1'b1;
    len   = l;
    @(negedge rclk);
    start = 1'b0;
    len   = 8'($urandom);
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int d0;
    d0 = done_cnt;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge rclk);
      #3;
      if (done_cnt > d0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rrst_n = 1'b0;
    repeat (3) @(negedge rclk);
    #3;
    n_cmp++;
    if ({rinc, m_valid, busy, done} !== 4'b0 || m_data !== 32'd0 || rd_count !== 8'd0 || checksum !== 32'd0) begin
      n_err++;
      $display("FAIL reset_outputs: rinc=%0b m_valid=%0b busy=%0b done=%0b m_data=%0d rd_count=%0d checksum=%0d required all 0",
               rinc, m_valid, busy, done, m_data, rd_count, checksum);
    end
    @(negedge rclk);
    rrst_n = 1'b1;
    repeat (2) @(negedge rclk);
  endtask

  task automatic test_full_burst();
    int r0, d0;
    bit ok;
    for (int i = 0; i < 16; i++) preload(32'(100 - i));
    repeat (2) @(negedge rclk);
    m_ready = 1'b1;
    r0 = rinc_cnt;
    d0 = done_cnt;
    do_start(8'd16);
    wait_done(200, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL full_done_timeout: no done within 200 cycles"); end
    repeat (2) @(negedge rclk);
    #3;
    n_cmp++;
    if (rinc_cnt - r0 != 16) begin n_err++; $display("FAIL full_rinc_count: got %0d required 16", rinc_cnt - r0); end
    n_cmp++;
    if (rd_count !== 8'd16) begin n_err++; $display("FAIL full_rd_count: got %0d required 16", rd_count); end
    n_cmp++;
    if (checksum !== 32'd1480) begin n_err++; $display("FAIL full_checksum: got %0d required 1480", checksum); end
    n_cmp++;
    if (done_cnt - d0 != 1) begin n_err++; $display("FAIL full_done_pulses: got %0d required 1", done_cnt - d0); end
    n_cmp++;
    if (rempty !== 1'b1 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL full_drained: rempty=%0b undelivered=%0d required 1 and 0", rempty, exp_q.size());
    end
  endtask

  task automatic test_len_zero();
    int r0;
    r0 = rinc_cnt;
    busy_seen = 1'b0;
    do_start(8'd0);
    #3;
    n_cmp++;
    if (done !== 1'b1) begin n_err++; $display("FAIL zero_done: got %0b required 1", done); end
    @(negedge rclk);
    #3;
    n_cmp++;
    if (done !== 1'b0) begin n_err++; $display("FAIL zero_done_width: got %0b required 0", done); end
    repeat (2) @(negedge rclk);
    #3;
    n_cmp++;
    if (rinc_cnt != r0 || busy_seen !== 1'b0 || rd_count !== 8'd0) begin
      n_err++;
      $display("FAIL zero_quiet: rinc=%0d busy_seen=%0b rd_count=%0d required 0 0 0", rinc_cnt - r0, busy_seen, rd_count);
    end
  endtask

  task automatic test_backpressure();
    int r0;
    bit ok;
    for (int i = 0; i < 4; i++) preload(32'h1000 + 32'(i));
    repeat (2) @(negedge rclk);
    m_ready = 1'b0;
    r0 = rinc_cnt;
    do_start(8'd4);
    repeat (10) @(negedge rclk);
    #3;
    n_cmp++;
    if (rinc_cnt - r0 != 2) begin n_err++; $display("FAIL bp_two_pops: got %0d required 2", rinc_cnt - r0); end
    n_cmp++;
    if (m_valid !== 1'b1 || m_data !== 32'h1000) begin
      n_err++;
      $display("FAIL bp_head: got v=%0b d=%0h required v=1 d=1000", m_valid, m_data);
    end
    @(negedge rclk);
    m_ready = 1'b1;
    wait_done(50, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL bp_done_timeout: no done within 50 cycles"); end
    n_cmp++;
    if (rinc_cnt - r0 != 4 || rd_count !== 8'd4 || checksum !== 32'h4006) begin
      n_err++;
      $display("FAIL bp_totals: rinc=%0d rd_count=%0d checksum=%0h required 4 4 4006", rinc_cnt - r0, rd_count, checksum);
    end
  endtask

  task automatic test_restart_busy();
    int r0, d0;
    bit ok;
    for (int i = 0; i < 8; i++) preload(32'd7 * 32'(i) + 32'd3);
    repeat (2) @(negedge rclk);
    m_ready = 1'b1;
    r0 = rinc_cnt;
    d0 = done_cnt;
    do_start(8'd6);
    @(negedge rclk);
    start = 1'b1;
    len   = 8'd3;
    @(negedge rclk);
    start = 1'b0;
    wait_done(80, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL restart_done_timeout: no done within 80 cycles"); end
    n_cmp++;
    if (rd_count !== 8'd6 || rinc_cnt - r0 != 6 || done_cnt - d0 != 1) begin
      n_err++;
      $display("FAIL restart_totals: rd_count=%0d rinc=%0d done=%0d required 6 6 1", rd_count, rinc_cnt - r0, done_cnt - d0);
    end
    n_cmp++;
    if (exp_q.size() != 2) begin n_err++; $display("FAIL restart_leftover: got %0d required 2", exp_q.size()); end
    repeat (2) @(negedge rclk);
    q.delete();
    exp_q.delete();
    repeat (2) @(negedge rclk);
  endtask

  task automatic test_concurrent();
    int r0;
    bit ok;
    logic [31:0] sum;
    m_ready = 1'b1;
    r0 = rinc_cnt;
    stall_cnt = 0;
    ok = 1'b0;
    sum = '0;
    for (int i = 0; i < 16; i++) sum += 32'h55 + 32'(i * 11);
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          #50;
          q.push_back(32'h55 + 32'(i * 11));
          exp_q.push_back(32'h55 + 32'(i * 11));
        end
      end
      begin
        do_start(8'd16);
        wait_done(200, ok);
      end
    join
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL conc_done_timeout: no done within 200 cycles"); end
    n_cmp++;
    if (rinc_cnt - r0 != 16 || rd_count !== 8'd16 || checksum !== sum) begin
      n_err++;
      $display("FAIL conc_totals: rinc=%0d rd_count=%0d checksum=%0d required 16 16 %0d", rinc_cnt - r0, rd_count, checksum, sum);
    end
    n_cmp++;
    if (stall_cnt == 0 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL conc_stalls: stalls=%0d undelivered=%0d required >0 and 0", stall_cnt, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int r0, d0;
    bit ok;
    for (int i = 0; i < 8; i++) preload(32'hA0 + 32'(i));
    repeat (2) @(negedge rclk);
    m_ready = 1'b1;
    r0 = rinc_cnt;
    d0 = done_cnt;
    do_start(8'd8);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      #3;
      if (rinc_cnt - r0 >= 3) begin ok = 1'b1; break; end
      @(negedge rclk);
    end
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL rstmid_progress: got %0d pops required 3", rinc_cnt - r0); end
    @(negedge rclk);
    rrst_n = 1'b0;
    @(negedge rclk);
    #3;
    n_cmp++;
    if ({rinc, m_valid, busy, done} !== 4'b0 || m_data !== 32'd0 || rd_count !== 8'd0 || checksum !== 32'd0) begin
      n_err++;
      $display("FAIL rstmid_outputs: rinc=%0b m_valid=%0b busy=%0b done=%0b m_data=%0d rd_count=%0d checksum=%0d required all 0",
               rinc, m_valid, busy, done, m_data, rd_count, checksum);
    end
    rrst_n = 1'b1;
    repeat (3) @(negedge rclk);
    #3;
    n_cmp++;
    if (done_cnt != d0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_no_done: done=%0d busy=%0b required 0 0", done_cnt - d0, busy);
    end
    q.delete();
    exp_q.delete();
    for (int i = 0; i < 5; i++) preload(32'd200 + 32'(i));
    repeat (2) @(negedge rclk);
    do_start(8'd5);
    wait_done(60, ok);
    n_cmp++;
    if (!ok || rd_count !== 8'd5 || checksum !== 32'd1010 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL rstmid_restart: ok=%0b rd_count=%0d checksum=%0d undelivered=%0d required 1 5 1010 0",
               ok, rd_count, checksum, exp_q.size());
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      int          l;
      int          fed;
      int          d0;
      bit          ok;
      logic [31:0] sum;
      logic [31:0] w [$];
      l   = int'($urandom_range(1, 24));
      sum = '0;
      for (int i = 0; i < l; i++) begin
        w.push_back($urandom);
        sum += w[i];
      end
      fed = 0;
      d0  = done_cnt;
      ok  = 1'b0;
      m_ready = 1'b1;
      do_start(8'(l));
      for (int c = 0; c < 1000; c++) begin
        @(negedge rclk);
        m_ready = ($urandom_range(0, 3) != 0);
        if (fed < l && $urandom_range(0, 1) == 1) begin
          preload(w[fed]);
          fed++;
        end
        #3;
        if (done_cnt > d0) begin ok = 1'b1; break; end
      end
      m_ready = 1'b1;
      n_cmp++;
      if (!ok || rd_count !== 8'(l) || checksum !== sum || exp_q.size() != 0) begin
        n_err++;
        $display("FAIL rand_burst%0d: ok=%0b rd_count=%0d checksum=%0h undelivered=%0d required 1 %0d %0h 0",
                 it, ok, rd_count, checksum, exp_q.size(), l, sum);
      end
      repeat (2) @(negedge rclk);
    end
  endtask

  task automatic test_max_len();
    int r0;
    bit ok;
    logic [31:0] sum;
    sum = '0;
    for (int i = 0; i < 255; i++) begin
      preload(32'(i * 3 + 7));
      sum += 32'(i * 3 + 7);
    end
    repeat (2) @(negedge rclk);
    m_ready = 1'b1;
    r0 = rinc_cnt;
    do_start(8'd255);
    wait_done(600, ok);
    n_cmp++;
    if (!ok || rinc_cnt - r0 != 255 || rd_count !== 8'd255 || checksum !== sum) begin
      n_err++;
      $display("FAIL max_len: ok=%0b rinc=%0d rd_count=%0d checksum=%0d required 1 255 255 %0d",
               ok, rinc_cnt - r0, rd_count, checksum, sum);
    end
  endtask

  initial begin
    rrst_n  = 1'b0;
    start   = 1'b0;
    len     = '0;
    m_ready = 1'b1;
    rempty  = 1'b1;
    rdata   = '0;
    test_reset();
    test_full_burst();
    test_len_zero();
    test_backpressure();
    test_restart_busy();
    test_concurrent();
    test_reset_mid();
    test_random();
    test_max_len();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_rd_drain.md
FIFO_RD_DRAIN -- requirements
Module: fifo_rd_drain

Interface
REQ-001 Parameter DSIZE, default 32, data word width (matches async_fifo DSIZE).
REQ-002 Parameter CSIZE, default 8, width of burst-length and word counters.
REQ-003 rclk  input  1  sole clock; read-side clock of async_fifo.
REQ-004 rrst_n  input  1  reset; one clock, reset is synchronous and active-low.
REQ-005 start  input  1  single-cycle request to drain len words.
REQ-006 len  input  CSIZE  burst length, sampled when start is accepted.
REQ-007 rempty  input  1  async_fifo empty flag.
REQ-008 rdata  input  DSIZE  async_fifo read data; valid in the same cycle as rinc while rempty=0.
REQ-009 rinc  output  1  async_fifo pop strobe.
REQ-010 m_data  output  DSIZE  downstream data.
REQ-011 m_valid  output  1  downstream valid.
REQ-012 m_ready  input  1  downstream ready.
REQ-013 busy  output  1  high from start acceptance until done.
REQ-014 done  output  1  one-cycle completion pulse.
REQ-015 rd_count  output  CSIZE  words popped in the current or last burst.
REQ-016 checksum  output  DSIZE  modulo-2^DSIZE sum of words popped in the current or last burst.

Function
REQ-017 FSM states: IDLE, READ, FLUSH, DONE.
REQ-018 IDLE->READ on start=1 with len!=0; rd_count and checksum clear to 0; remaining loads len.
REQ-019 IDLE->DONE on start=1 with len=0; no rinc is issued.
REQ-020 start is ignored in every state except IDLE.
REQ-021 rinc = (state==READ) & !rempty & (remaining!=0) & (skid occupancy!=2); combinational from registers and rempty only, never from m_ready.
REQ-022 On each rinc cycle: rdata is pushed into the skid buffer, remaining decrements by 1, rd_count increments by 1, and checksum adds rdata with the carry discarded.
REQ-023 rempty=1 in READ stalls rinc without changing state; there is no timeout.
REQ-024 READ->FLUSH in the cycle after the pop that makes remaining=0.
REQ-025 FLUSH->DONE when skid occupancy is 0.
REQ-026 In DONE, done=1 for exactly one cycle, then the FSM returns to IDLE.
REQ-027 busy=1 in READ and FLUSH; busy=0 in IDLE and DONE.
REQ-028 Skid buffer: 2-entry, in-order; m_valid=(occupancy!=0); m_data is the head entry; a word pops when m_valid&m_ready.
REQ-029 Simultaneous push and pop leaves occupancy unchanged and preserves order.
REQ-030 Latency: a word popped at edge N is presented on m_data/m_valid after edge N when the buffer was empty.
REQ-031 m_data is held stable while m_valid=1 and m_ready=0.
REQ-032 rd_count and checksum hold their values after done until the next accepted start.
REQ-033 rd_count never exceeds len; len=2^CSIZE-1 is supported.

Reset
REQ-034 While rrst_n=0 at rclk edge: state=IDLE, remaining=0, rd_count=0, checksum=0, occupancy=0.
REQ-035 Output values in reset: rinc=0, m_valid=0, m_data=0, busy=0, done=0.
REQ-036 Reset asserted mid-burst discards buffered words; no done is generated; words already popped from async_fifo are lost.

Structure
REQ-037 Package fifo_rd_pkg holds the FSM state enum (IDLE, READ, FLUSH, DONE) and default DSIZE/CSIZE constants.
REQ-038 The skid buffer is a sub-module named fifo_rd_skid2, parameterized by DSIZE, with push/pop/occupancy ports.

Verification
REQ-039 Preload 16 words 100..85 (fifo full), start len=16, m_ready=1 -> 16 rinc pulses, m_data 100..85 in order, rd_count=16, checksum=1480, single done pulse, rempty=1 at end.
REQ-040 start len=0 -> no rinc, done one cycle later, busy never high, rd_count=0.
REQ-041 Concurrent writer at 50 ns period, reader at 32 ns period, len=16 -> rinc only while rempty=0, with stalls between words; all 16 words delivered in order.
REQ-042 Preload 4 words, len=4, m_ready=0 for 10 cycles -> exactly 2 rinc pulses, then no rinc, m_data held; after m_ready=1 the remaining 2 words are popped and done follows.
REQ-043 start pulsed again while busy -> ignored; rd_count finishes at the original len.
REQ-044 rrst_n=0 for 1 cycle after 3 of 8 words -> all outputs 0, state IDLE, no done; a new start len=5 completes normally.
